// File: rtl/edge_pattern_gen.sv
// edge_pattern_gen: serial MSB-first level-pattern transmitter with per-bit stretch and transition count.
module edge_pattern_gen #(
    parameter  int WIDTH   = 21,
    parameter  int BIT_CYC = 1,
    localparam int LW      = $clog2(WIDTH + 1),
    localparam int CW      = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LW-1:0]    len,
    output logic             dout,
    output logic             busy,
    output logic             done,
    input  logic             abort,
    output logic [CW-1:0]    edge_cnt
);
    localparam int PW = BIT_CYC > 1 ? $clog2(BIT_CYC) : 1;
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] sr_q;
    logic [LW-1:0]    bits_q;
    logic [PW-1:0]    cyc_q;
    logic [CW-1:0]    run_q;
    logic [CW-1:0]    edge_cnt_q;
    logic             dout_q;
    logic             busy_q;
    logic             done_q;
    logic [LW-1:0]    len_c;
    logic             last_cyc;
    logic             last_bit;
    logic             dout_d;
    logic [CW-1:0]    run_d;
    always_comb begin
        len_c    = (len == '0 || len > LW'(WIDTH)) ? LW'(WIDTH) : len;
        last_cyc = cyc_q == PW'(BIT_CYC - 1);
        last_bit = bits_q == LW'(1);
        // level for the next cycle: hold, advance to the next bit, or return to idle 0
        dout_d   = !last_cyc ? sr_q[WIDTH-1] : (!last_bit && sr_q[WIDTH-2]);
        run_d    = run_q + CW'(dout_d != dout_q);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            bits_q     <= '0;
            cyc_q      <= '0;
            run_q      <= '0;
            edge_cnt_q <= '0;
            dout_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (load_valid) begin
                    state_q <= SHIFT;
                    sr_q    <= pattern;
                    bits_q  <= len_c;
                    cyc_q   <= '0;
                    run_q   <= CW'(pattern[WIDTH-1]);
                    dout_q  <= pattern[WIDTH-1];
                    busy_q  <= 1'b1;
                end
            end else if (abort) begin
                state_q <= IDLE;
                dout_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                run_q  <= run_d;
                dout_q <= dout_d;
                cyc_q  <= last_cyc ? '0 : cyc_q + 1'b1;
                if (last_cyc) begin
                    sr_q   <= sr_q << 1;
                    bits_q <= bits_q - 1'b1;
                end
                if (last_cyc && last_bit) begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    edge_cnt_q <= run_d;
                end
            end
        end
    end
    assign load_ready = state_q == IDLE;
    assign dout       = dout_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign edge_cnt   = edge_cnt_q;
endmodule

// File: tb/tb_edge_pattern_gen.sv
// tb_edge_pattern_gen: directed and random frames on two instances (BIT_CYC 1 and 3) against a level-sequence model.
module tb_edge_pattern_gen;
    localparam int W  = 21;
    localparam int LW = $clog2(W + 1);
    localparam int CW = $clog2(W + 2);
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    logic [1:0]         lv, ab, lr, dq, bz, dn;
    logic [1:0][W-1:0]  pat;
    logic [1:0][LW-1:0] ln;
    logic [1:0][CW-1:0] ec;
    int n_chk = 0;
    int n_pass = 0;
    int exp_ec [2];
    edge_pattern_gen #(.WIDTH(W), .BIT_CYC(1)) dut0 (
        .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(lr[0]), .pattern(pat[0]), .len(ln[0]),
        .dout(dq[0]), .busy(bz[0]), .done(dn[0]), .abort(ab[0]), .edge_cnt(ec[0])
    );
    edge_pattern_gen #(.WIDTH(W), .BIT_CYC(3)) dut1 (
        .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(lr[1]), .pattern(pat[1]), .len(ln[1]),
        .dout(dq[1]), .busy(bz[1]), .done(dn[1]), .abort(ab[1]), .edge_cnt(ec[1])
    );
    task automatic chk(string tag, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle_chk(int s, string tag);
        chk({tag, "_dout"}, dq[s], 0);
        chk({tag, "_busy"}, bz[s], 0);
        chk({tag, "_done"}, dn[s], 0);
        chk({tag, "_ready"}, lr[s], 1);
        chk({tag, "_ec"}, ec[s], exp_ec[s]);
    endtask
    task automatic load(int s, logic [W-1:0] p, int l);
        lv[s]  = 1'b1;
        pat[s] = p;
        ln[s]  = LW'(l);
    endtask
    // Expects load() already applied; returns in the done cycle or the cycle after an abort.
    task automatic frame(int s, logic [W-1:0] p, int l, int abort_at, bit junk);
        int  n     = (l == 0 || l > W) ? W : l;
        int  bc    = s ? 3 : 1;
        int  edges = 0;
        bit  prev  = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (p[W-1-k] != prev) edges++;
            prev = p[W-1-k];
        end
        if (prev) edges++;
        tick();
        lv[s] = 1'b0;
        ab[s] = 1'b0;
        for (int c = 1; c <= n * bc; c++) begin
            chk("bit_dout", dq[s], int'(p[W-1-(c-1)/bc]));
            chk("bit_busy", bz[s], 1);
            chk("bit_done", dn[s], 0);
            chk("bit_ready", lr[s], 0);
            if (junk && $urandom_range(3) == 0) begin
                lv[s]  = 1'b1;
                pat[s] = W'($urandom);
            end else lv[s] = 1'b0;
            if (c == abort_at) begin
                ab[s] = 1'b1;
                tick();
                ab[s] = 1'b0;
                lv[s] = 1'b0;
                idle_chk(s, "abort");
                return;
            end
            tick();
        end
        lv[s] = 1'b0;
        chk("end_dout", dq[s], 0);
        chk("end_busy", bz[s], 0);
        chk("end_done", dn[s], 1);
        chk("end_ready", lr[s], 1);
        chk("end_ec", ec[s], edges);
        exp_ec[s] = edges;
    endtask
    initial begin
        logic [W-1:0] p;
        int s, l, gap;
        lv = '0; ab = '0; pat = '0; ln = '0;
        exp_ec[0] = 0;
        exp_ec[1] = 0;
        repeat (2) begin
            tick();
            idle_chk(0, "rst");
            idle_chk(1, "rst");
        end
        rst = 1'b1;
        tick();
        idle_chk(0, "post_rst");
        idle_chk(1, "post_rst");
        p = 21'b001100101100010011010;
        load(0, p, 21);
        frame(0, p, 21, -1, 1'b0);
        chk("ref_ec", ec[0], 12);
        tick();
        idle_chk(0, "ref_after");
        load(0, W'($urandom) | 21'h100000, 21);
        frame(0, pat[0], 21, 6, 1'b1);
        chk("abort_ec", ec[0], 12);
        tick();
        idle_chk(0, "abort_after");
        p = W'($urandom);
        load(0, p, 9);
        frame(0, p, 9, -1, 1'b0);
        p = 21'h100000;
        load(1, p, 4);
        frame(1, p, 4, -1, 1'b0);
        chk("stretch_ec", ec[1], 2);
        p = W'($urandom) | 21'h100000;
        load(1, p, 0);
        frame(1, p, 0, -1, 1'b1);
        p = W'($urandom) | 21'h100000;
        load(1, p, 5);
        frame(1, p, 5, -1, 1'b0);
        ab[0] = 1'b1;
        tick();
        ab[0] = 1'b0;
        idle_chk(0, "idle_abort");
        ab[0] = 1'b1;
        p = W'($urandom);
        load(0, p, 7);
        frame(0, p, 7, -1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            s   = int'($urandom_range(1));
            p   = W'($urandom);
            l   = int'($urandom_range(31));
            load(s, p, l);
            frame(s, p, l, ($urandom_range(3) == 0) ? int'($urandom_range(1, 70)) : -1, 1'b1);
            gap = int'($urandom_range(2));
            repeat (gap) begin
                tick();
                idle_chk(s, "gap");
            end
        end
        p = 21'h1fffff;
        load(0, p, 21);
        tick();
        lv[0] = 1'b0;
        repeat (2) tick();
        chk("pre_rst_busy", bz[0], 1);
        #3 rst = 1'b0;
        #1;
        exp_ec[0] = 0;
        exp_ec[1] = 0;
        idle_chk(0, "async_rst");
        idle_chk(1, "async_rst");
        tick();
        rst = 1'b1;
        tick();
        idle_chk(0, "rst_release");
        p = W'($urandom);
        load(0, p, 12);
        frame(0, p, 12, -1, 1'b0);
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
